// File: rtl/line_raster_engine_pkg.sv
// Shared definitions for the line raster engine: FSM state codes, default widths
// and the visible screen extent (also used by the VGA timing generator).
package line_raster_engine_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int COLOR_W_DEF = 12;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;

    typedef enum logic [0:0] {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } step_dir_e;

    function automatic step_dir_e dir_of(input logic delta_negative);
        return delta_negative ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/line_step_core.sv
// One Bresenham iteration: from the current point and error term, produce the next
// point and error, plus a flag telling whether the current point is the endpoint.
module line_step_core
    import line_raster_engine_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic signed [COORD_W-1:0] x_i,
    input  logic signed [COORD_W-1:0] y_i,
    input  logic signed [COORD_W-1:0] x1_i,
    input  logic signed [COORD_W-1:0] y1_i,
    input  logic signed [COORD_W+1:0] err_i,
    input  logic signed [COORD_W+1:0] dx_i,
    input  logic signed [COORD_W+1:0] dy_i,
    input  step_dir_e                 sx_i,
    input  step_dir_e                 sy_i,
    output logic signed [COORD_W-1:0] x_o,
    output logic signed [COORD_W-1:0] y_o,
    output logic signed [COORD_W+1:0] err_o,
    output logic                      at_end_o
);

    localparam int EW = COORD_W + 2;

    logic signed [EW:0]        e2;
    logic signed [EW:0]        dx_w;
    logic signed [EW:0]        dy_w;
    logic                      step_x;
    logic                      step_y;
    logic signed [EW-1:0]      add_x;
    logic signed [EW-1:0]      add_y;
    logic signed [COORD_W-1:0] x_delta;
    logic signed [COORD_W-1:0] y_delta;

    always_comb begin
        e2      = {err_i, 1'b0};
        dx_w    = {dx_i[EW-1], dx_i};
        dy_w    = {dy_i[EW-1], dy_i};
        // Both decisions use the same e2, so a diagonal move takes both branches.
        step_x  = (e2 >= dy_w);
        step_y  = (e2 <= dx_w);
        add_x   = step_x ? dy_i : '0;
        add_y   = step_y ? dx_i : '0;
        err_o   = err_i + add_x + add_y;
        x_delta = (sx_i == DIR_NEG) ? '1 : COORD_W'(1);
        y_delta = (sy_i == DIR_NEG) ? '1 : COORD_W'(1);
        x_o     = step_x ? (x_i + x_delta) : x_i;
        y_o     = step_y ? (y_i + y_delta) : y_i;
        at_end_o = (x_i == x1_i) && (y_i == y1_i);
    end

endmodule

// File: rtl/line_raster_engine.sv
// Line rasteriser: accepts one endpoint pair + colour, walks it with Bresenham
// stepping and streams one pixel per cycle. Define LINE_CLIP_EN to suppress off-screen pixels.
module line_raster_engine
    import line_raster_engine_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF
) (
    input  logic                      VGA_CLK,
    input  logic                      RST,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [COORD_W-1:0] X0,
    input  logic signed [COORD_W-1:0] Y0,
    input  logic signed [COORD_W-1:0] X1,
    input  logic signed [COORD_W-1:0] Y1,
    input  logic        [COLOR_W-1:0] cmd_rgb,
    output logic                      px_valid,
    input  logic                      px_ready,
    output logic signed [COORD_W-1:0] px_x,
    output logic signed [COORD_W-1:0] px_y,
    output logic        [COLOR_W-1:0] px_rgb,
    output logic                      px_last,
    output logic                      busy,
    output logic                      done
);

    localparam int EW = COORD_W + 2;

`ifdef LINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic signed [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
    localparam logic signed [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

    logic [1:0]                state_q,  state_d;
    logic signed [COORD_W-1:0] x0_q,     x0_d;
    logic signed [COORD_W-1:0] y0_q,     y0_d;
    logic signed [COORD_W-1:0] x1_q,     x1_d;
    logic signed [COORD_W-1:0] y1_q,     y1_d;
    logic        [COLOR_W-1:0] rgb_q,    rgb_d;
    logic signed [COORD_W-1:0] x_q,      x_d;
    logic signed [COORD_W-1:0] y_q,      y_d;
    logic signed [EW-1:0]      err_q,    err_d;
    logic signed [EW-1:0]      dx_q,     dx_d;
    logic signed [EW-1:0]      dy_q,     dy_d;
    step_dir_e                 sx_q,     sx_d;
    step_dir_e                 sy_q,     sy_d;
    logic                      done_q,   done_d;

    logic signed [COORD_W-1:0] x_step;
    logic signed [COORD_W-1:0] y_step;
    logic signed [EW-1:0]      err_step;
    logic                      at_end;

    logic signed [EW-1:0]      x0_ext, y0_ext, x1_ext, y1_ext;
    logic signed [EW-1:0]      diff_x, diff_y;
    logic signed [EW-1:0]      dx_setup, dy_setup;

    logic                      in_bounds;
    logic                      visible;
    logic                      advance;

    line_step_core #(
        .COORD_W (COORD_W)
    ) u_step (
        .x_i      (x_q),
        .y_i      (y_q),
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_i     (sx_q),
        .sy_i     (sy_q),
        .x_o      (x_step),
        .y_o      (y_step),
        .err_o    (err_step),
        .at_end_o (at_end)
    );

    always_comb begin
        x0_ext   = {{2{x0_q[COORD_W-1]}}, x0_q};
        y0_ext   = {{2{y0_q[COORD_W-1]}}, y0_q};
        x1_ext   = {{2{x1_q[COORD_W-1]}}, x1_q};
        y1_ext   = {{2{y1_q[COORD_W-1]}}, y1_q};
        diff_x   = x1_ext - x0_ext;
        diff_y   = y1_ext - y0_ext;
        dx_setup = diff_x[EW-1] ? -diff_x : diff_x;
        // dy is kept as the negated magnitude so the error test reads e2 >= dy.
        dy_setup = diff_y[EW-1] ? diff_y : -diff_y;
    end

    always_comb begin
        in_bounds = !x_q[COORD_W-1] && (x_q < H_LIM) &&
                    !y_q[COORD_W-1] && (y_q < V_LIM);
        visible   = !CLIP_EN || in_bounds;
        // An invisible pixel never waits on the sink; it just burns its cycle.
        advance   = (state_q == ST_STEP) && (px_ready || !visible);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        rgb_d   = rgb_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = X0;
                    y0_d    = Y0;
                    x1_d    = X1;
                    y1_d    = Y1;
                    rgb_d   = cmd_rgb;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                x_d     = x0_q;
                y_d     = y0_q;
                dx_d    = dx_setup;
                dy_d    = dy_setup;
                err_d   = dx_setup + dy_setup;
                sx_d    = dir_of(diff_x[EW-1]);
                sy_d    = dir_of(diff_y[EW-1]);
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d   = x_step;
                        y_d   = y_step;
                        err_d = err_step;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            rgb_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= DIR_POS;
            sy_q    <= DIR_POS;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            rgb_q   <= rgb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        px_valid  = (state_q == ST_STEP) && visible;
        px_last   = px_valid && at_end;
        px_x      = x_q;
        px_y      = y_q;
        px_rgb    = rgb_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Scoreboard bench for line_raster_engine: directed lines push hand-computed pixels,
// an independent monitor pops and compares every accepted pixel and the done pulse.
module tb_line_raster_engine;

    localparam int CW = 11;
    localparam int RW = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        [RW-1:0] rgb = '0;
    logic                 px_valid;
    logic                 px_ready = 1'b1;
    logic signed [CW-1:0] px_x, px_y;
    logic        [RW-1:0] px_rgb;
    logic                 px_last, busy, done;

    always #5 clk = ~clk;

    line_raster_engine dut (
        .VGA_CLK   (clk),
        .RST       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .X0        (x0),
        .Y0        (y0),
        .X1        (x1),
        .Y1        (y1),
        .cmd_rgb   (rgb),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_rgb    (px_rgb),
        .px_last   (px_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic signed [CW-1:0] x;
        logic signed [CW-1:0] y;
        logic        [RW-1:0] c;
        logic                 last;
    } px_t;

    px_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int c, input bit last);
        px_t p;
        p.x = CW'(x);
        p.y = CW'(y);
        p.c = RW'(c);
        p.last = last;
        exp_q.push_back(p);
    endtask

    // Returns just after the accepting edge, i.e. inside the SETUP cycle.
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1); rgb = RW'(c);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("cmd (%0d,%0d)->(%0d,%0d) rgb %03h accepted at %0t", ax0, ay0, ax1, ay1, c, $time);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, int'(exp_q.size() == 0 && !busy), 1);
        @(negedge clk);
    endtask

    // Monitor: pops on every accepted pixel; done must follow the last pixel by one cycle.
    initial begin : monitor
        px_t  e;
        logic prev_last_fire;
        logic exp_done;
        prev_last_fire = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_last_fire = 1'b0;
            end else begin
                exp_done = prev_last_fire;
                if (done || exp_done) check("done_pulse", int'(done), int'(exp_done));
                prev_last_fire = px_valid && px_ready && px_last;
                if (px_valid && px_ready) begin
                    $display("px (%0d,%0d) rgb %03h last %0d at %0t", px_x, px_y, px_rgb, px_last, $time);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pixel: got (%0d,%0d), required none", px_x, px_y);
                    end else begin
                        e = exp_q.pop_front();
                        check("px_x", int'(px_x), int'(e.x));
                        check("px_y", int'(px_y), int'(e.y));
                        check("px_rgb", int'(px_rgb), int'(e.c));
                        check("px_last", int'(px_last), int'(e.last));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_px_valid", int'(px_valid), 0);
        check("rst_px_x", int'(px_x), 0);
        check("rst_px_y", int'(px_y), 0);
        check("rst_px_rgb", int'(px_rgb), 0);
        check("rst_px_last", int'(px_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Horizontal: first pixel two cycles after accept.
        push(0, 0, 'hF00, 0); push(1, 0, 'hF00, 0); push(2, 0, 'hF00, 0); push(3, 0, 'hF00, 1);
        issue(0, 0, 3, 0, 'hF00);
        @(negedge clk);
        check("horiz_setup_px_valid", int'(px_valid), 0);
        @(negedge clk);
        check("horiz_first_px_valid", int'(px_valid), 1);
        wait_done("horiz_complete");

        // Steep
        push(0, 0, 'h0F0, 0); push(0, 1, 'h0F0, 0); push(1, 2, 'h0F0, 0); push(1, 3, 'h0F0, 1);
        issue(0, 0, 1, 3, 'h0F0);
        wait_done("steep_complete");

        // Reversed horizontal
        push(5, 2, 'h00F, 0); push(4, 2, 'h00F, 0); push(3, 2, 'h00F, 0); push(2, 2, 'h00F, 1);
        issue(5, 2, 2, 2, 'h00F);
        wait_done("reversed_complete");

        // Shallow, both directions negative
        push(10, 5, 'h123, 0); push(9, 4, 'h123, 0); push(8, 4, 'h123, 0);
        push(7, 3, 'h123, 0); push(6, 3, 'h123, 1);
        issue(10, 5, 6, 3, 'h123);
        wait_done("shallow_neg_complete");

        // Diagonal with three stall cycles on (1,1)
        push(0, 0, 'hABC, 0); push(1, 1, 'hABC, 0); push(2, 2, 'hABC, 0); push(3, 3, 'hABC, 1);
        issue(0, 0, 3, 3, 'hABC);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 px_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_px_valid", int'(px_valid), 1);
            check("stall_px_x", int'(px_x), 1);
            check("stall_px_y", int'(px_y), 1);
            check("stall_px_rgb", int'(px_rgb), 'hABC);
        end
        @(posedge clk);
        #1 px_ready = 1'b1;
        wait_done("diag_bp_complete");

        // Degenerate point with cycle-exact handshake timing
        push(7, 7, 'h777, 1);
        issue(7, 7, 7, 7, 'h777);
        @(negedge clk);
        check("point_n1_cmd_ready", int'(cmd_ready), 0);
        check("point_n1_busy", int'(busy), 1);
        @(negedge clk);
        check("point_n2_cmd_ready", int'(cmd_ready), 0);
        check("point_n2_px_valid", int'(px_valid), 1);
        @(negedge clk);
        check("point_n3_done", int'(done), 1);
        check("point_n3_cmd_ready", int'(cmd_ready), 1);
        check("point_n3_px_valid", int'(px_valid), 0);
        wait_done("point_complete");

        // Reset after the second pixel of a long line
        for (int i = 0; i < 10; i++) push(i, 0, 'h0AA, (i == 9));
        issue(0, 0, 9, 0, 'h0AA);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_px_valid", int'(px_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_pixels_left", exp_q.size(), 8);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_abort_cmd_ready", int'(cmd_ready), 1);
        check("post_abort_done", int'(done), 0);

        push(5, 2, 'h0C0, 0); push(4, 2, 'h0C0, 0); push(3, 2, 'h0C0, 0); push(2, 2, 'h0C0, 1);
        issue(5, 2, 2, 2, 'h0C0);
        wait_done("post_abort_complete");

        // Line starting left of the screen
`ifdef LINE_CLIP_EN
        push(0, 0, 'hFFF, 0); push(1, 0, 'hFFF, 1);
`else
        push(-2, 0, 'hFFF, 0); push(-1, 0, 'hFFF, 0); push(0, 0, 'hFFF, 0); push(1, 0, 'hFFF, 1);
`endif
        issue(-2, 0, 1, 0, 'hFFF);
        wait_done("offscreen_complete");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_raster_engine.md
# line_raster_engine

Parametrised, sequential successor to the combinational line-membership test: accepts one line command (two endpoints plus colour) over a valid/ready handshake, then walks the line with integer Bresenham stepping and emits one pixel per cycle on a backpressured stream. It sits between the scene/command logic and the framebuffer write port, in the VGA_CLK domain.

## Interface
- COORD_W, 11: signed coordinate width (covers ±1023).
- COLOR_W, 12: pixel colour width (RGB 4:4:4).
- H_RES, 640: horizontal visible extent, used only with clipping.
- V_RES, 480: vertical visible extent, used only with clipping.

- VGA_CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid && cmd_ready.
- X0, Y0, X1, Y1  in  COORD_W each, signed  endpoints; sampled on accept.
- cmd_rgb  in  COLOR_W  line colour; sampled on accept.
- px_valid  out  1  pixel present.
- px_ready  in  1  sink accepts pixel.
- px_x, px_y  out  COORD_W each, signed  pixel coordinate.
- px_rgb  out  COLOR_W  pixel colour.
- px_last  out  1  pixel is endpoint (X1,Y1).
- busy  out  1  command in progress (not IDLE).
- done  out  1  one-cycle pulse on return to IDLE after a completed line.

## Operation
- FSM: IDLE -> SETUP on accept; SETUP -> STEP unconditionally; STEP -> IDLE when endpoint handled; STEP holds otherwise.
- SETUP: dx = |X1-X0|, dy = -|Y1-Y0|, sx = (X1>=X0)?+1:-1, sy = (Y1>=Y0)?+1:-1, err = dx+dy, (x,y) = (X0,Y0).
- Widths: dx/dy/err are signed COORD_W+2; e2 = 2*err is COORD_W+3. No overflow for any legal input.
- STEP, when current pixel consumed: if (x,y)==(X1,Y1) finish; else e2 = 2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}. Both updates may occur in one step.
- Pixel count = max(dx,|dy|)+1. Degenerate point (X0,Y0)==(X1,Y1): exactly one pixel, px_last=1.
- Stream rule: while px_valid && !px_ready, px_x/px_y/px_rgb/px_last hold stable and no stepping occurs.
- cmd_ready = (state==IDLE); no command queuing; cmd_valid ignored while busy.
- Reset values: cmd_ready=1 after reset release, px_valid=0, px_x=px_y=0, px_rgb=0, px_last=0, busy=0, done=0, FSM=IDLE.
- RST mid-line: line abandoned immediately, no done pulse, no further pixels.

## Timing
- Accept at edge N; SETUP during cycle N+1; first px_valid at N+2.
- Throughput 1 pixel/cycle with px_ready held high; line of P pixels occupies cycles N+2..N+P+1.
- done pulses the cycle after the final pixel is consumed (or skipped); cmd_ready high that same cycle, so back-to-back commands cost 2 bubble cycles.
- cmd_ready combinationally independent of cmd_valid; px_valid independent of px_ready (no comb path ready->valid).

## Configuration
- LINE_CLIP_EN defined: pixels with x<0, x>=H_RES, y<0 or y>=V_RES are suppressed (px_valid stays 0 for that step, one cycle consumed, stepping continues). px_last asserts only if the endpoint itself is visible; done always pulses at completion.
- Undefined: every pixel emitted regardless of coordinate; H_RES/V_RES unused.

## Structure
- Shared package: state encoding (IDLE/SETUP/STEP), default COORD_W/COLOR_W, H_RES/V_RES screen constants reused by VGA timing.
- One natural sub-module: line_step_core (combinational e2/err/x/y next-step computation), instantiated once; FSM and handshake stay in the top.

## Test plan
- Horizontal (0,0)->(3,0), rgb 0xF00, px_ready=1 -> (0,0),(1,0),(2,0),(3,0) on consecutive cycles, px_last on (3,0), done next cycle.
- Steep (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3); reversed (5,2)->(2,2) -> x=5,4,3,2 at y=2.
- Backpressure on diagonal (0,0)->(3,3): px_ready low 3 cycles on (1,1) -> output held stable, sequence unchanged, 4 pixels total.
- Point (7,7)->(7,7) -> single pixel, px_last=1; cmd_ready low during N+1..N+2, high with done.
- RST asserted after 2nd pixel of (0,0)->(9,0) -> px_valid=0 same cycle, no done, cmd_ready=1 after release; next command runs correctly.
- LINE_CLIP_EN, (-2,0)->(1,0) -> only (0,0),(1,0) emitted, px_last on (1,0), done after 4 step cycles.
